// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencing controller between the execute stage and a
// single-port req/gnt/rvalid data bus.
//
// Accepts one load or store per transaction, checks alignment, issues the bus
// request with byte enables and lane-replicated store data, and stalls the
// pipeline until completion. Loads return sign/zero-extended data for
// write-back. Misaligned accesses and bus timeouts are reported as faults.
//
// Ports:
//   clk_in, reset_in             clock (rising edge), synchronous active-high reset
//   mem_op_in/addr/data/rd_addr  request from execute stage (held while stalled)
//   stall_out                    freeze upstream pipeline
//   wb_we/addr/data_out          load write-back (DONE cycle only)
//   misalign/fault/fault_addr    exception report (DONE cycle only)
//   bus_*_out                    bus request fields (REQ state only, 0 elsewhere)
//   bus_gnt/rvalid/rdata_in      bus response
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a non-NOP op; accepts and latches it
// REQ   | bus_req_out asserted until gnt or timeout
// WAIT  | load granted, waiting for rvalid or timeout
// DONE  | one-cycle completion: write-back or fault report

module lsu_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic [3:0]            mem_op_in,
    input  logic [ADDR_WIDTH-1:0] mem_addr_in,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [4:0]            rd_addr_in,
    output logic                  stall_out,
    output logic                  wb_we_out,
    output logic [4:0]            wb_addr_out,
    output logic [DATA_WIDTH-1:0] wb_data_out,
    output logic                  misalign_out,
    output logic                  fault_out,
    output logic [ADDR_WIDTH-1:0] fault_addr_out,
    output logic                  bus_req_out,
    output logic                  bus_we_out,
    output logic [ADDR_WIDTH-1:0] bus_addr_out,
    output logic [3:0]            bus_be_out,
    output logic [DATA_WIDTH-1:0] bus_wdata_out,
    input  logic                  bus_gnt_in,
    input  logic                  bus_rvalid_in,
    input  logic [DATA_WIDTH-1:0] bus_rdata_in
);

    localparam logic [3:0] MEM_NOP = 4'd0;
    localparam logic [3:0] LB      = 4'd1;
    localparam logic [3:0] LBU     = 4'd2;
    localparam logic [3:0] LH      = 4'd3;
    localparam logic [3:0] LHU     = 4'd4;
    localparam logic [3:0] LW      = 4'd5;
    localparam logic [3:0] SB      = 4'd6;
    localparam logic [3:0] SH      = 4'd7;
    localparam logic [3:0] SW      = 4'd8;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [4:0]            rd_q, rd_d;
    logic                  misalign_q, misalign_d;
    logic                  fault_q, fault_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] ldata_q, ldata_d;

    logic                  mis_in;
    logic                  op_is_store;
    logic                  op_is_load;
    logic                  op_is_byte;
    logic                  op_is_half;
    logic                  timeout_hit;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [DATA_WIDTH-1:0] ld_ext;

    always_comb begin
        mis_in = 1'b0;
        case (mem_op_in)
            LH, LHU, SH: mis_in = mem_addr_in[0];
            LW, SW:      mis_in = (mem_addr_in[1:0] != 2'b00);
            default:     mis_in = 1'b0;
        endcase
    end

    assign op_is_store = (op_q == SB) || (op_q == SH) || (op_q == SW);
    assign op_is_load  = (op_q == LB) || (op_q == LBU) || (op_q == LH) ||
                         (op_q == LHU) || (op_q == LW);
    assign op_is_byte  = (op_q == LB) || (op_q == LBU) || (op_q == SB);
    assign op_is_half  = (op_q == LH) || (op_q == LHU) || (op_q == SH);
    assign timeout_hit = (cnt_q == TMO_LAST);

    // Lane extraction from the returned word using the latched address.
    always_comb begin
        rd_byte = 8'h00;
        case (addr_q[1:0])
            2'd0: rd_byte = bus_rdata_in[7:0];
            2'd1: rd_byte = bus_rdata_in[15:8];
            2'd2: rd_byte = bus_rdata_in[23:16];
            2'd3: rd_byte = bus_rdata_in[31:24];
            default: rd_byte = 8'h00;
        endcase
        rd_half = addr_q[1] ? bus_rdata_in[31:16] : bus_rdata_in[15:0];

        ld_ext = bus_rdata_in;
        case (op_q)
            LB:      ld_ext = {{(DATA_WIDTH-8){rd_byte[7]}}, rd_byte};
            LBU:     ld_ext = {{(DATA_WIDTH-8){1'b0}}, rd_byte};
            LH:      ld_ext = {{(DATA_WIDTH-16){rd_half[15]}}, rd_half};
            LHU:     ld_ext = {{(DATA_WIDTH-16){1'b0}}, rd_half};
            default: ld_ext = bus_rdata_in;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q    <= IDLE;
            op_q       <= MEM_NOP;
            addr_q     <= '0;
            data_q     <= '0;
            rd_q       <= '0;
            misalign_q <= 1'b0;
            fault_q    <= 1'b0;
            cnt_q      <= '0;
            ldata_q    <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rd_q       <= rd_d;
            misalign_q <= misalign_d;
            fault_q    <= fault_d;
            cnt_q      <= cnt_d;
            ldata_q    <= ldata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rd_d       = rd_q;
        misalign_d = misalign_q;
        fault_d    = fault_q;
        cnt_d      = cnt_q;
        ldata_d    = ldata_q;

        case (state_q)
            IDLE: begin
                if (mem_op_in != MEM_NOP) begin
                    op_d       = mem_op_in;
                    addr_d     = mem_addr_in;
                    data_d     = mem_data_in;
                    rd_d       = rd_addr_in;
                    misalign_d = mis_in;
                    fault_d    = 1'b0;
                    cnt_d      = '0;
                    ldata_d    = '0;
                    state_d    = mis_in ? DONE : REQ;
                end
            end
            REQ: begin
                cnt_d = cnt_q + 8'd1;
                // A grant in the same cycle as expiry still completes the access.
                if (bus_gnt_in) begin
                    state_d = op_is_store ? DONE : WAIT;
                end else if (timeout_hit) begin
                    fault_d = 1'b1;
                    state_d = DONE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (bus_rvalid_in) begin
                    ldata_d = ld_ext;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    fault_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        stall_out      = 1'b0;
        wb_we_out      = 1'b0;
        wb_addr_out    = '0;
        wb_data_out    = '0;
        misalign_out   = 1'b0;
        fault_out      = 1'b0;
        fault_addr_out = '0;
        bus_req_out    = 1'b0;
        bus_we_out     = 1'b0;
        bus_addr_out   = '0;
        bus_be_out     = 4'b0000;
        bus_wdata_out  = '0;

        case (state_q)
            IDLE: begin
                stall_out = (mem_op_in != MEM_NOP);
            end
            REQ: begin
                stall_out    = 1'b1;
                bus_req_out  = 1'b1;
                bus_we_out   = op_is_store;
                bus_addr_out = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                if (op_is_byte) begin
                    bus_be_out    = 4'b0001 << addr_q[1:0];
                    bus_wdata_out = {(DATA_WIDTH/8){data_q[7:0]}};
                end else if (op_is_half) begin
                    bus_be_out    = 4'b0011 << {addr_q[1], 1'b0};
                    bus_wdata_out = {(DATA_WIDTH/16){data_q[15:0]}};
                end else begin
                    bus_be_out    = 4'b1111;
                    bus_wdata_out = data_q;
                end
            end
            WAIT: begin
                stall_out = 1'b1;
            end
            DONE: begin
                if (op_is_load && !fault_q && !misalign_q && (rd_q != 5'd0)) begin
                    wb_we_out   = 1'b1;
                    wb_addr_out = rd_q;
                    wb_data_out = ldata_q;
                end
                misalign_out = misalign_q;
                fault_out    = fault_q;
                if (misalign_q || fault_q) begin
                    fault_addr_out = addr_q;
                end
            end
            default: begin
                stall_out = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

    localparam int TO = 16;

    localparam logic [3:0] MEM_NOP = 4'd0;
    localparam logic [3:0] LB      = 4'd1;
    localparam logic [3:0] LBU     = 4'd2;
    localparam logic [3:0] LH      = 4'd3;
    localparam logic [3:0] LHU     = 4'd4;
    localparam logic [3:0] LW      = 4'd5;
    localparam logic [3:0] SB      = 4'd6;
    localparam logic [3:0] SH      = 4'd7;
    localparam logic [3:0] SW      = 4'd8;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [3:0]  mem_op_in;
    logic [31:0] mem_addr_in;
    logic [31:0] mem_data_in;
    logic [4:0]  rd_addr_in;
    logic        stall_out;
    logic        wb_we_out;
    logic [4:0]  wb_addr_out;
    logic [31:0] wb_data_out;
    logic        misalign_out;
    logic        fault_out;
    logic [31:0] fault_addr_out;
    logic        bus_req_out;
    logic        bus_we_out;
    logic [31:0] bus_addr_out;
    logic [3:0]  bus_be_out;
    logic [31:0] bus_wdata_out;
    logic        bus_gnt_in;
    logic        bus_rvalid_in;
    logic [31:0] bus_rdata_in;

    lsu_ctrl #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_in(clk_in),
        .reset_in(reset_in),
        .mem_op_in(mem_op_in),
        .mem_addr_in(mem_addr_in),
        .mem_data_in(mem_data_in),
        .rd_addr_in(rd_addr_in),
        .stall_out(stall_out),
        .wb_we_out(wb_we_out),
        .wb_addr_out(wb_addr_out),
        .wb_data_out(wb_data_out),
        .misalign_out(misalign_out),
        .fault_out(fault_out),
        .fault_addr_out(fault_addr_out),
        .bus_req_out(bus_req_out),
        .bus_we_out(bus_we_out),
        .bus_addr_out(bus_addr_out),
        .bus_be_out(bus_be_out),
        .bus_wdata_out(bus_wdata_out),
        .bus_gnt_in(bus_gnt_in),
        .bus_rvalid_in(bus_rvalid_in),
        .bus_rdata_in(bus_rdata_in)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        mis;
        logic        flt;
        logic [31:0] faddr;
        int          lat;
        int          reqs;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> (8 * int'(a[1:0]));
        case (op)
            LB:      return {{24{sh[7]}}, sh[7:0]};
            LBU:     return {24'h0, sh[7:0]};
            LH:      return {{16{sh[15]}}, sh[15:0]};
            LHU:     return {16'h0, sh[15:0]};
            default: return rdata;
        endcase
    endfunction

    task automatic do_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] rd, input int gnt_dly, input int rv_dly,
                          input logic [31:0] rdata);
        exp_t        e;
        exp_t        got_e;
        logic        is_ld, is_st, mis, tmo;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        int          cyc, reqc, wc;
        bit          got_gnt, done;

        is_st = (op == SB) || (op == SH) || (op == SW);
        is_ld = !is_st;
        mis   = ((op == LH || op == LHU || op == SH) && addr[0]) ||
                ((op == LW || op == SW) && addr[1:0] != 2'b00);
        tmo   = !mis && (gnt_dly >= TO);
        case (op)
            LB, LBU, SB: begin exp_be = 4'b0001 << addr[1:0]; exp_wd = {4{data[7:0]}}; end
            LH, LHU, SH: begin exp_be = addr[1] ? 4'b1100 : 4'b0011; exp_wd = {2{data[15:0]}}; end
            default:     begin exp_be = 4'b1111; exp_wd = data; end
        endcase

        e.we    = is_ld && !mis && !tmo && (rd != 5'd0);
        e.waddr = rd;
        e.wdata = model_load(op, addr, rdata);
        e.mis   = mis;
        e.flt   = tmo;
        e.faddr = (mis || tmo) ? addr : 32'h0;
        if (mis)        begin e.lat = 2;                    e.reqs = 0; end
        else if (tmo)   begin e.lat = TO + 2;               e.reqs = TO; end
        else if (is_st) begin e.lat = gnt_dly + 3;          e.reqs = gnt_dly + 1; end
        else            begin e.lat = gnt_dly + rv_dly + 4; e.reqs = gnt_dly + 1; end
        sb_q.push_back(e);

        @(negedge clk_in);
        mem_op_in     = op;
        mem_addr_in   = addr;
        mem_data_in   = data;
        rd_addr_in    = rd;
        bus_gnt_in    = 1'b0;
        bus_rvalid_in = 1'b0;
        bus_rdata_in  = rdata;
        #1;
        cyc = 0; reqc = 0; wc = 0; got_gnt = 0; done = 0;
        while (!done && cyc < 64) begin
            if (!stall_out) begin
                done = 1;
            end else begin
                if (bus_req_out) begin
                    if (reqc == 0) begin
                        check_val("bus_addr", bus_addr_out, {addr[31:2], 2'b00});
                        check_val("bus_be", {28'h0, bus_be_out}, {28'h0, exp_be});
                        check_val("bus_we", {31'h0, bus_we_out}, {31'h0, is_st});
                        if (is_st) check_val("bus_wdata", bus_wdata_out, exp_wd);
                    end
                    reqc++;
                    bus_gnt_in = (reqc > gnt_dly);
                    if (bus_gnt_in) got_gnt = 1;
                end else if (got_gnt) begin
                    wc++;
                    bus_rvalid_in = (wc > rv_dly);
                end
                @(posedge clk_in);
                @(negedge clk_in);
                bus_gnt_in    = 1'b0;
                bus_rvalid_in = 1'b0;
                #1;
                cyc++;
            end
        end

        if (!done) begin
            check_val("txn_bound", 32'(cyc), 32'(e.lat - 1));
            void'(sb_q.pop_front());
        end else begin
            got_e = sb_q.pop_front();
            check_val("latency", 32'(cyc + 1), 32'(got_e.lat));
            check_val("req_cycles", 32'(reqc), 32'(got_e.reqs));
            check_val("wb_we", {31'h0, wb_we_out}, {31'h0, got_e.we});
            if (got_e.we) begin
                check_val("wb_addr", {27'h0, wb_addr_out}, {27'h0, got_e.waddr});
                check_val("wb_data", wb_data_out, got_e.wdata);
            end
            check_val("misalign", {31'h0, misalign_out}, {31'h0, got_e.mis});
            check_val("fault", {31'h0, fault_out}, {31'h0, got_e.flt});
            check_val("fault_addr", fault_addr_out, got_e.faddr);
            check_val("done_bus_idle", {27'h0, bus_req_out, bus_be_out}, 32'h0);
        end
        mem_op_in = MEM_NOP;
        @(posedge clk_in);
    endtask

    initial begin
        reset_in      = 1'b1;
        mem_op_in     = MEM_NOP;
        mem_addr_in   = 32'h0;
        mem_data_in   = 32'h0;
        rd_addr_in    = 5'd0;
        bus_gnt_in    = 1'b0;
        bus_rvalid_in = 1'b0;
        bus_rdata_in  = 32'h0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        #1;
        check_val("rst_stall", {31'h0, stall_out}, 32'h0);
        check_val("rst_bus", {26'h0, bus_req_out, bus_we_out, bus_be_out}, 32'h0);
        check_val("rst_bus_data", bus_addr_out | bus_wdata_out, 32'h0);
        check_val("rst_wb", {26'h0, wb_we_out, wb_addr_out}, 32'h0);
        check_val("rst_exc", {31'h0, misalign_out | fault_out}, 32'h0);
        reset_in = 1'b0;
        @(posedge clk_in);

        //        op   addr          data          rd     gnt   rv  rdata
        do_txn(LW,  32'h0000_0100, 32'h0,        5'd5,  0,    0,  32'hDEAD_BEEF);
        do_txn(LB,  32'h0000_0103, 32'h0,        5'd6,  0,    0,  32'h80FF_1234);
        do_txn(LBU, 32'h0000_0103, 32'h0,        5'd6,  0,    0,  32'h80FF_1234);
        do_txn(SH,  32'h0000_0202, 32'h0000_ABCD, 5'd0, 3,    0,  32'h0);
        do_txn(LW,  32'h0000_0101, 32'h0,        5'd4,  0,    0,  32'h0);
        do_txn(LH,  32'h0000_0300, 32'h0,        5'd9,  1000, 0,  32'h0);
        do_txn(SB,  32'h0000_0005, 32'h1234_5678, 5'd0, 0,    0,  32'h0);
        do_txn(LH,  32'h0000_0102, 32'h0,        5'd7,  1,    2,  32'h8001_7FFF);
        do_txn(LHU, 32'h0000_0100, 32'h0,        5'd0,  0,    0,  32'h8001_8FFF);
        do_txn(LHU, 32'h0000_0102, 32'h0,        5'd8,  0,    1,  32'h8001_7FFF);
        do_txn(SW,  32'h0000_0204, 32'hCAFE_F00D, 5'd0, 2,    0,  32'h0);
        do_txn(LH,  32'h0000_0301, 32'h0,        5'd3,  0,    0,  32'h0);
        do_txn(SW,  32'h0000_0206, 32'h1111_2222, 5'd0, 0,    0,  32'h0);
        do_txn(LB,  32'h0000_0400, 32'h0,        5'd31, 14,   0,  32'h0000_007F);
        do_txn(SB,  32'h0000_0500, 32'h0000_00A5, 5'd0, 15,   0,  32'h0);

        // Reset while a load is waiting for rvalid; the late rvalid must be dropped.
        @(negedge clk_in);
        mem_op_in    = LW;
        mem_addr_in  = 32'h0000_0040;
        rd_addr_in   = 5'd3;
        bus_rdata_in = 32'h1234_5678;
        @(posedge clk_in);
        @(negedge clk_in);
        #1;
        check_val("rstmid_req", {31'h0, bus_req_out}, 32'h1);
        bus_gnt_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        bus_gnt_in = 1'b0;
        #1;
        check_val("rstmid_wait_stall", {31'h0, stall_out}, 32'h1);
        reset_in  = 1'b1;
        mem_op_in = MEM_NOP;
        @(posedge clk_in);
        @(negedge clk_in);
        reset_in      = 1'b0;
        bus_rvalid_in = 1'b1;
        #1;
        check_val("rstmid_stall", {31'h0, stall_out}, 32'h0);
        check_val("rstmid_outs", {25'h0, bus_req_out, bus_we_out, bus_be_out, wb_we_out},
                  32'h0);
        @(posedge clk_in);
        @(negedge clk_in);
        bus_rvalid_in = 1'b0;
        #1;
        check_val("rstmid_no_wb", {31'h0, wb_we_out}, 32'h0);
        check_val("rstmid_exc", {29'h0, misalign_out, fault_out, stall_out}, 32'h0);
        check_val("rstmid_wbdata", wb_data_out | fault_addr_out | bus_addr_out, 32'h0);

        // A normal store after the reset still works.
        do_txn(SB,  32'h0000_0042, 32'h0000_0033, 5'd0, 0,    0,  32'h0);

        check_val("sb_empty", 32'(sb_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencing controller between the execute stage's memory request outputs and the single-port data bus. It accepts one load or store per transaction and checks alignment. It drives a req/gnt/rvalid bus with byte enables and lane-replicated write data. It stalls the pipeline until the access completes, then returns sign- or zero-extended load data for write-back, or reports a misalignment or bus-timeout fault.

## Interface
- `TIMEOUT_CYCLES`, 16: cycles spent in REQ+WAIT without gnt/rvalid before a bus fault is raised; range 1–255.
- `clk_in` in 1: clock, rising edge.
- `reset_in` in 1: reset, synchronous and active-high.
- `mem_op_in` in 4: `MEM_NOP`/`LB`/`LBU`/`LH`/`LHU`/`LW`/`SB`/`SH`/`SW` from defines.v; held stable by upstream while `stall_out`=1.
- `mem_addr_in` in `ADDR_WIDTH`: byte address.
- `mem_data_in` in `DATA_WIDTH`: store data, low bits significant.
- `rd_addr_in` in 5: load destination register.
- `stall_out` out 1: freeze upstream pipeline.
- `wb_we_out` out 1, `wb_addr_out` out 5, `wb_data_out` out `DATA_WIDTH`: load write-back.
- `misalign_out` out 1, `fault_out` out 1, `fault_addr_out` out `ADDR_WIDTH`: exception report.
- `bus_req_out` out 1, `bus_we_out` out 1, `bus_addr_out` out `ADDR_WIDTH`, `bus_be_out` out 4, `bus_wdata_out` out `DATA_WIDTH`: bus request.
- `bus_gnt_in` in 1, `bus_rvalid_in` in 1, `bus_rdata_in` in `DATA_WIDTH`: bus response.

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset → IDLE.
- The controller latches op, address, data, rd and a misalign flag on acceptance. It also clears an 8-bit timeout counter.
- **IDLE**
  - `mem_op_in`≠`MEM_NOP` → accept.
  - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0) → DONE with the misalign flag set.
  - Otherwise → REQ.
- **REQ**
  - `bus_req_out`=1; the request holds until `bus_gnt_in`=1.
  - On gnt: store → DONE; load → WAIT.
- **WAIT**
  - Waits for `bus_rvalid_in`.
  - On rvalid it captures the lane selected by latched addr[1:0] (byte) or addr[1] (half), then sign-extends (LB/LH) or zero-extends (LBU/LHU) → DONE.
- Timeout: the counter increments each cycle in REQ/WAIT. At `TIMEOUT_CYCLES` → DONE with the fault flag set; the request drops and no write-back occurs.
- **DONE**
  - One cycle, always → IDLE.
  - `mem_op_in` is ignored (it still shows the completed op).
- Bus encoding, valid in REQ only; all fields are 0 outside REQ:
  - `bus_addr_out` = {addr[31:2],2'b00}.
  - `bus_be_out`: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'b1111.
  - `bus_wdata_out`: SB {4{d[7:0]}}, SH {2{d[15:0]}}, SW d.
  - `bus_we_out` = 1 for stores.
- `bus_rvalid_in` outside WAIT is ignored. rvalid is legal no earlier than the cycle after gnt.

## Timing
- Reset values: every output is 0; state is IDLE; the counter and all latches are 0.
- `stall_out` is combinational:
  - 1 in IDLE when `mem_op_in`≠`MEM_NOP`.
  - 1 in REQ and WAIT.
  - 0 in DONE and in IDLE with NOP.
- DONE-cycle outputs:
  - `wb_we_out`=1 only for a load with no fault, no misalign, and rd≠0.
  - `wb_addr_out`/`wb_data_out` are valid whenever `wb_we_out`=1.
  - `misalign_out` or `fault_out` pulses 1 with `fault_addr_out` = the latched byte address.
  - All are 0 in other states.
- Latency, zero-wait bus: store = 3 cycles (accept, REQ+gnt, DONE); load = 4 cycles (accept, REQ+gnt, WAIT+rvalid, DONE). Each gnt wait cycle adds 1; each rvalid wait cycle adds 1.
- Misaligned access: 2 cycles (accept, DONE); no bus activity.
- Reset mid-transaction: state → IDLE on the same edge, and `bus_req_out` is 0 from the next cycle. A late rvalid is ignored and no write-back occurs.
- Simultaneous timeout expiry and gnt/rvalid: gnt/rvalid wins.

## Test plan
- LW addr 0x100, gnt in REQ cycle 1, rdata 0xDEADBEEF next cycle, rd=5 → `bus_be_out`=1111. DONE in cycle 3 with `wb_we_out`=1, `wb_addr_out`=5, `wb_data_out`=0xDEADBEEF. `stall_out` is 1,1,1,0.
- LB addr 0x103 and LBU addr 0x103, rdata 0x80FF1234 → be=1000; LB gives wb_data 0xFFFFFF80, LBU gives 0x00000080.
- SH addr 0x202, data 0x0000ABCD, gnt delayed 3 cycles → `bus_req_out` held 4 cycles, be=1100, wdata 0xABCDABCD, `bus_we_out`=1. DONE with no write-back; total 6 cycles.
- LW addr 0x101 → no `bus_req_out`; DONE has `misalign_out`=1 and `fault_addr_out`=0x101.
- LH addr 0x300 with gnt never asserted, `TIMEOUT_CYCLES`=16 → `fault_out`=1 after 16 REQ cycles, req drops, `wb_we_out`=0. The next SB proceeds normally.
- Load with gnt, then `reset_in` pulsed in WAIT, then rvalid the next cycle → IDLE; `stall_out`=0; no write-back; all outputs 0.
